// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg: shared types and constants for the counter-increment scheduler.
// Holds the grant FSM encoding, default slot length and requester indices.
package ctr_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEF_SLOT_CYCLES = 12;

   localparam int REQ_T1 = 0;
   localparam int REQ_T3 = 1;
   localparam int REQ_T4 = 2;
   localparam int REQ_T5 = 3;
   localparam int REQ_T6 = 4;

endpackage

// File: rtl/ctr_incr_sched_if.sv
// ctr_incr_sched_if: request/grant bundle between scaler, scheduler and
// counter sequencer. The scheduler is the slave side.
interface ctr_incr_sched_if #(
   parameter int NREQ = 5,
   parameter int PW   = 4
);
   logic [NREQ-1:0] req_pulse;
   logic            slot_sync;
   logic            inhibit;
   logic            ack;
   logic            lost_clr;
   logic [NREQ-1:0] grant;
   logic            grant_valid;
   logic [NREQ-1:0] pending;
   logic [NREQ-1:0] lost;
   logic [PW-1:0]   slot_phase;

   modport master (
      output req_pulse, slot_sync, inhibit, ack, lost_clr,
      input  grant, grant_valid, pending, lost, slot_phase
   );

   modport slave (
      input  req_pulse, slot_sync, inhibit, ack, lost_clr,
      output grant, grant_valid, pending, lost, slot_phase
   );
endinterface

// File: rtl/ctr_prio_pick.sv
// ctr_prio_pick: one-hot winner from a pending vector, searching upward
// from a start index and wrapping at NREQ-1.
module ctr_prio_pick #(
   parameter int NREQ = 5,
   parameter int SW   = 3
) (
   input  logic [NREQ-1:0] pend,
   input  logic [SW-1:0]   start,
   output logic [NREQ-1:0] win
);
   logic [SW:0] pos;
   logic        found;

   // First set bit at or after start, modulo NREQ
   always_comb begin
      win   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, start} + (SW+1)'(k);
         if (pos >= (SW+1)'(NREQ))
            pos = pos - (SW+1)'(NREQ);
         if (!found && pend[pos[SW-1:0]]) begin
            win[pos[SW-1:0]] = 1'b1;
            found            = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ctr_incr_sched.sv
// ctr_incr_sched: grants one latched counter-increment request per slot.
// Optional macro SCHED_ROUND_ROBIN_EN selects rotating priority.
module ctr_incr_sched
   import ctr_sched_pkg::*;
#(
   parameter int NREQ        = 5,
   parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
   parameter int PW          = 4
) (
   input logic             clk,
   input logic             rst_,
   ctr_incr_sched_if.slave bus
);
   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0] LAST = PW'(SLOT_CYCLES - 1);

   state_t          state;
   logic [PW-1:0]   phase;
   logic [NREQ-1:0] pend;
   logic [NREQ-1:0] lost;
   logic [NREQ-1:0] grant;
   logic            gvalid;
   logic [NREQ-1:0] win;
   logic [NREQ-1:0] clr;
   logic [SW-1:0]   start;
   logic            arb;

   assign clr = grant & {NREQ{bus.ack}};
   assign arb = (state == IDLE) && (phase == LAST)
              && !bus.inhibit && (|pend);

   ctr_prio_pick #(
      .NREQ (NREQ),
      .SW   (SW)
   ) u_pick (
      .pend  (pend),
      .start (start),
      .win   (win)
   );

`ifdef SCHED_ROUND_ROBIN_EN
   logic [SW-1:0] ptr;
   logic [SW-1:0] win_idx;

   // Encode the one-hot winner back to an index for the pointer
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (win[i]) win_idx = SW'(i);
   end

   assign start = (ptr == SW'(NREQ-1)) ? '0 : ptr + SW'(1);

   // Remember the last granted requester so the search rotates past it
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)    ptr <= SW'(NREQ-1);
      else if (arb) ptr <= win_idx;
   end
`else
   assign start = '0;
`endif

   // Slot phase counter, resynchronised by slot_sync
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         phase <= '0;
      else if (bus.slot_sync || phase == LAST)
         phase <= '0;
      else
         phase <= phase + PW'(1);
   end

   // Pending latch and sticky overrun flags; a new request beats its clear
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         pend <= '0;
         lost <= '0;
      end else begin
         pend <= bus.req_pulse | (pend & ~clr);
         lost <= (bus.lost_clr ? '0 : lost)
               | (bus.req_pulse & pend & ~clr);
      end
   end

   // Grant FSM: arbitrate on the last phase, hold until ack
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state  <= IDLE;
         grant  <= '0;
         gvalid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (arb) begin
               state  <= GRANT;
               grant  <= win;
               gvalid <= 1'b1;
            end
            GRANT: if (bus.ack) begin
               state  <= IDLE;
               grant  <= '0;
               gvalid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant       = grant;
   assign bus.grant_valid = gvalid;
   assign bus.pending     = pend;
   assign bus.lost        = lost;
   assign bus.slot_phase  = phase;
endmodule

// File: tb/tb_ctr_incr_sched.sv
// tb_ctr_incr_sched: directed scenarios plus randomized traffic checked
// against an index-level scheduler model.
module tb_ctr_incr_sched;
   import ctr_sched_pkg::*;

   localparam int NREQ = 5;
   localparam int SLOT = DEF_SLOT_CYCLES;
   localparam int PW   = 4;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int         m_phase;
   logic [4:0] m_pend;
   logic [4:0] m_lost;
   int         m_gidx;
   int         m_last;

   ctr_incr_sched_if #(.NREQ(NREQ), .PW(PW)) bus ();

   ctr_incr_sched #(
      .NREQ        (NREQ),
      .SLOT_CYCLES (SLOT),
      .PW          (PW)
   ) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [4:0] m_grant();
      return (m_gidx < 0) ? 5'b0 : (5'b00001 << m_gidx);
   endfunction

   function automatic void model_reset();
      m_phase = 0;
      m_pend  = '0;
      m_lost  = '0;
      m_gidx  = -1;
      m_last  = NREQ - 1;
   endfunction

   function automatic void model_step(logic [4:0] rq, logic a,
                                      logic inh, logic lc, logic ss);
      logic [4:0] cl;
      logic [4:0] np;
      logic [4:0] nl;
      int first;
      int pick;
      cl = (m_gidx >= 0 && a) ? (5'b00001 << m_gidx) : 5'b0;
      np = rq | (m_pend & ~cl);
      nl = (lc ? 5'b0 : m_lost) | (rq & m_pend & ~cl);
`ifdef SCHED_ROUND_ROBIN_EN
      first = (m_last + 1) % NREQ;
`else
      first = 0;
`endif
      if (m_gidx >= 0) begin
         if (a) m_gidx = -1;
      end else if (m_phase == SLOT-1 && !inh && m_pend != 0) begin
         pick = -1;
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (first + k) % NREQ;
            if (pick < 0 && ((m_pend >> j) & 5'b00001) != 0) pick = j;
         end
         m_gidx = pick;
         m_last = pick;
      end
      m_phase = ss ? 0 : (m_phase + 1) % SLOT;
      m_pend  = np;
      m_lost  = nl;
   endfunction

   task automatic tick();
      logic [4:0] rq;
      logic a, inh, lc, ss;
      rq  = bus.req_pulse;
      a   = bus.ack;
      inh = bus.inhibit;
      lc  = bus.lost_clr;
      ss  = bus.slot_sync;
      @(posedge clk);
      if (!rst_) model_reset();
      else       model_step(rq, a, inh, lc, ss);
      #1;
   endtask

   task automatic goto_phase(int p);
      for (int n = 0; n < 2*SLOT && m_phase != p; n++) tick();
   endtask

   task automatic wait_grant(output int waited);
      waited = 0;
      while (!bus.grant_valid && waited < 3*SLOT) begin
         tick();
         waited++;
      end
   endtask

   task automatic test_reset();
      bus.req_pulse = '0;
      bus.slot_sync = 0;
      bus.inhibit   = 0;
      bus.ack       = 0;
      bus.lost_clr  = 0;
      rst_ = 1'b0;
      model_reset();
      #2;
      checks++;
      if (bus.grant !== 5'b0) begin
         errors++; $display("FAIL reset_grant: got %b want 00000", bus.grant);
      end
      checks++;
      if (bus.grant_valid !== 1'b0) begin
         errors++; $display("FAIL reset_gv: got %b want 0", bus.grant_valid);
      end
      checks++;
      if (bus.pending !== 5'b0) begin
         errors++; $display("FAIL reset_pending: got %b want 00000", bus.pending);
      end
      checks++;
      if (bus.lost !== 5'b0) begin
         errors++; $display("FAIL reset_lost: got %b want 00000", bus.lost);
      end
      checks++;
      if (bus.slot_phase !== 4'd0) begin
         errors++; $display("FAIL reset_phase: got %0d want 0", bus.slot_phase);
      end
      #2 rst_ = 1'b1;
      tick();
      checks++;
      if (bus.slot_phase !== 4'd1) begin
         errors++; $display("FAIL phase_inc: got %0d want 1", bus.slot_phase);
      end
   endtask

   task automatic test_single();
      goto_phase(3);
      bus.req_pulse = 5'b1 << REQ_T4;
      tick();
      bus.req_pulse = '0;
      checks++;
      if (bus.pending !== 5'b00100) begin
         errors++; $display("FAIL single_pending: got %b want 00100", bus.pending);
      end
      goto_phase(SLOT-1);
      checks++;
      if (bus.grant_valid !== 1'b0) begin
         errors++; $display("FAIL single_early: got %b want 0", bus.grant_valid);
      end
      tick();
      checks++;
      if (bus.grant !== 5'b00100 || bus.grant_valid !== 1'b1 ||
          bus.slot_phase !== 4'd0) begin
         errors++;
         $display("FAIL single_grant: got %b/%b ph %0d want 00100/1 ph 0",
                  bus.grant, bus.grant_valid, bus.slot_phase);
      end
      goto_phase(4);
      bus.ack = 1;
      tick();
      bus.ack = 0;
      checks++;
      if (bus.grant !== 5'b0 || bus.grant_valid !== 1'b0 ||
          bus.pending !== 5'b0) begin
         errors++;
         $display("FAIL single_ack: got %b/%b pend %b want 00000/0 pend 00000",
                  bus.grant, bus.grant_valid, bus.pending);
      end
   endtask

   task automatic test_slot_sync();
      goto_phase(7);
      bus.slot_sync = 1;
      tick();
      bus.slot_sync = 0;
      checks++;
      if (bus.slot_phase !== 4'd0) begin
         errors++; $display("FAIL sync_zero: got %0d want 0", bus.slot_phase);
      end
      goto_phase(SLOT-1);
      tick();
      checks++;
      if (bus.slot_phase !== 4'd0) begin
         errors++; $display("FAIL phase_wrap: got %0d want 0", bus.slot_phase);
      end
   endtask

   task automatic test_priority();
      int w;
      logic [4:0] e1, e2;
`ifdef SCHED_ROUND_ROBIN_EN
      e1 = 5'b01000;
      e2 = 5'b00010;
`else
      e1 = 5'b00010;
      e2 = 5'b01000;
`endif
      bus.req_pulse = 5'b1 << REQ_T3;
      tick();
      bus.req_pulse = '0;
      wait_grant(w);
      checks++;
      if (bus.grant !== 5'b00010) begin
         errors++; $display("FAIL prio_prior: got %b want 00010", bus.grant);
      end
      bus.ack = 1;
      tick();
      bus.ack = 0;
      bus.req_pulse = (5'b1 << REQ_T3) | (5'b1 << REQ_T5);
      tick();
      bus.req_pulse = '0;
      wait_grant(w);
      checks++;
      if (bus.grant !== e1 || bus.slot_phase !== 4'd0) begin
         errors++;
         $display("FAIL prio_first: got %b ph %0d want %b ph 0",
                  bus.grant, bus.slot_phase, e1);
      end
      bus.ack = 1;
      tick();
      bus.ack = 0;
      wait_grant(w);
      checks++;
      if (bus.grant !== e2 || w != SLOT-1) begin
         errors++;
         $display("FAIL prio_second: got %b after %0d want %b after %0d",
                  bus.grant, w, e2, SLOT-1);
      end
      bus.ack = 1;
      tick();
      bus.ack = 0;
   endtask

   task automatic test_lost();
      bus.inhibit = 1;
      bus.req_pulse = 5'b1 << REQ_T1;
      tick();
      tick();
      bus.req_pulse = '0;
      checks++;
      if (bus.lost !== 5'b00001 || bus.pending !== 5'b00001) begin
         errors++;
         $display("FAIL lost_set: got %b pend %b want 00001 pend 00001",
                  bus.lost, bus.pending);
      end
      repeat (3) tick();
      checks++;
      if (bus.lost !== 5'b00001) begin
         errors++; $display("FAIL lost_sticky: got %b want 00001", bus.lost);
      end
      bus.lost_clr = 1;
      tick();
      bus.lost_clr = 0;
      checks++;
      if (bus.lost !== 5'b0) begin
         errors++; $display("FAIL lost_clr: got %b want 00000", bus.lost);
      end
      bus.lost_clr = 1;
      bus.req_pulse = 5'b00001;
      tick();
      bus.lost_clr = 0;
      bus.req_pulse = '0;
      checks++;
      if (bus.lost !== 5'b00001) begin
         errors++; $display("FAIL lost_set_wins: got %b want 00001", bus.lost);
      end
      bus.lost_clr = 1;
      tick();
      bus.lost_clr = 0;
      goto_phase(SLOT-1);
      tick();
      checks++;
      if (bus.grant_valid !== 1'b0) begin
         errors++; $display("FAIL inhibit_block: got %b want 0", bus.grant_valid);
      end
      bus.inhibit = 0;
      tick();
      goto_phase(0);
      checks++;
      if (bus.grant !== 5'b00001 || bus.grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL inhibit_release: got %b/%b want 00001/1",
                  bus.grant, bus.grant_valid);
      end
      bus.ack = 1;
      tick();
      bus.ack = 0;
   endtask

   task automatic test_coincide();
      int w;
      bus.req_pulse = 5'b1 << REQ_T6;
      tick();
      bus.req_pulse = '0;
      wait_grant(w);
      checks++;
      if (bus.grant !== 5'b10000) begin
         errors++; $display("FAIL coin_grant: got %b want 10000", bus.grant);
      end
      bus.req_pulse = 5'b10000;
      bus.ack = 1;
      tick();
      bus.req_pulse = '0;
      bus.ack = 0;
      checks++;
      if (bus.pending !== 5'b10000 || bus.lost !== 5'b0 ||
          bus.grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL coin_keep: pend %b lost %b gv %b want 10000 00000 0",
                  bus.pending, bus.lost, bus.grant_valid);
      end
      wait_grant(w);
      checks++;
      if (bus.grant !== 5'b10000 || w != SLOT-1) begin
         errors++;
         $display("FAIL coin_regrant: got %b after %0d want 10000 after %0d",
                  bus.grant, w, SLOT-1);
      end
      bus.ack = 1;
      tick();
      bus.ack = 0;
   endtask

   task automatic test_hold_reset();
      int w;
      bus.req_pulse = 5'b00100;
      tick();
      bus.req_pulse = '0;
      wait_grant(w);
      for (int n = 0; n < 3*SLOT; n++) begin
         tick();
         checks++;
         if (bus.grant !== 5'b00100 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_grant: got %b/%b want 00100/1",
                     bus.grant, bus.grant_valid);
         end
      end
      goto_phase(5);
      rst_ = 1'b0;
      #1;
      model_reset();
      checks++;
      if (bus.grant !== 5'b0 || bus.grant_valid !== 1'b0 ||
          bus.pending !== 5'b0 || bus.lost !== 5'b0 ||
          bus.slot_phase !== 4'd0) begin
         errors++;
         $display("FAIL async_reset: g %b gv %b p %b l %b ph %0d want all 0",
                  bus.grant, bus.grant_valid, bus.pending,
                  bus.lost, bus.slot_phase);
      end
      #2 rst_ = 1'b1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         bus.req_pulse = '0;
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(7) == 0) bus.req_pulse[i] = 1'b1;
         bus.ack       = ($urandom_range(2) == 0);
         bus.inhibit   = ($urandom_range(5) == 0);
         bus.lost_clr  = ($urandom_range(9) == 0);
         bus.slot_sync = ($urandom_range(29) == 0);
         tick();
         checks++;
         if (bus.grant !== m_grant() || bus.grant_valid !== (m_gidx >= 0)) begin
            errors++;
            $display("FAIL rnd_grant: got %b/%b want %b/%b",
                     bus.grant, bus.grant_valid, m_grant(), m_gidx >= 0);
         end
         checks++;
         if (bus.pending !== m_pend) begin
            errors++;
            $display("FAIL rnd_pending: got %b want %b", bus.pending, m_pend);
         end
         checks++;
         if (bus.lost !== m_lost) begin
            errors++;
            $display("FAIL rnd_lost: got %b want %b", bus.lost, m_lost);
         end
         checks++;
         if (bus.slot_phase !== PW'(m_phase)) begin
            errors++;
            $display("FAIL rnd_phase: got %0d want %0d",
                     bus.slot_phase, m_phase);
         end
      end
      bus.req_pulse = '0;
      bus.ack       = 0;
      bus.inhibit   = 0;
      bus.lost_clr  = 0;
      bus.slot_sync = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_slot_sync();
      test_priority();
      test_lost();
      test_coincide();
      test_hold_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctr_incr_sched.md
Name: ctr_incr_sched

Overview:
- Schedules timer counter-increment requests from the scaler phase pulses (FS/F..A/F..B outputs) into the shared counter-increment slot.
- One increment is granted per memory-cycle slot.
- Pending increments are latched, arbitrated by priority, and held until the counter logic acknowledges.
- Sits between the scaler (A1) and the counter-cell increment sequencer.

Parameters:
- NREQ, 5, number of increment requesters (TIME1, TIME3, TIME4, TIME5, TIME6 order; index 0 highest).
- SLOT_CYCLES, 12, clocks per memory-cycle slot (time pulses T01..T12).
- PW, 4, width of slot_phase; must satisfy 2^PW >= SLOT_CYCLES.

Ports:
- clk  in  1  master clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- req_pulse  in  NREQ  one-clock increment request pulses from scaler decode.
- slot_sync  in  1  forces the slot phase to 0 on the next clock.
- inhibit  in  1  blocks new grants (counter sequence inhibited).
- ack  in  1  counter logic has performed the granted increment.
- grant  out  NREQ  one-hot granted requester; all zero when idle.
- grant_valid  out  1  a grant is outstanding.
- pending  out  NREQ  latched, not-yet-serviced requests.
- lost  out  NREQ  sticky overrun flags.
- lost_clr  in  1  clears all lost flags.
- slot_phase  out  PW  current slot phase, 0..SLOT_CYCLES-1.

Behaviour:
- Reset (rst_ low, asynchronous):
  - grant=0, grant_valid=0, pending=0, lost=0, slot_phase=0, state=IDLE.
  - Reset mid-grant drops the grant immediately; the request is lost without setting the lost flag.
- Slot counter:
  - Increments each clock and wraps from SLOT_CYCLES-1 to 0.
  - slot_sync=1 forces the next value to 0, overriding the increment.
- Pending latch, per bit i:
  - Set: req_pulse[i].
  - Clear: ack while grant[i].
  - If set and clear occur in the same cycle, set wins and the bit stays 1.
- Lost flag, per bit i: set when req_pulse[i]=1 while pending[i]=1 and the bit is not being cleared that cycle.
  - lost_clr clears all flags.
  - If a lost set and lost_clr occur in the same cycle, set wins.
- State machine states: IDLE, GRANT.
- IDLE → GRANT:
  - Occurs at the clock edge where slot_phase==SLOT_CYCLES-1, inhibit=0 and pending!=0.
  - The winning bit is the lowest index set in pending as sampled that cycle; a req_pulse arriving in the same cycle does not participate.
  - grant and grant_valid become visible at phase 0 of the next slot, so latency from pending to grant is at most SLOT_CYCLES clocks.
- GRANT → IDLE on ack:
  - grant and grant_valid clear the cycle after ack.
  - The next arbitration is at the next occurrence of phase SLOT_CYCLES-1; if ack lands on phase SLOT_CYCLES-1, there is no arbitration that edge.
  - This guarantees at most one grant per slot.
- While in GRANT:
  - The grant holds across slot boundaries indefinitely until ack.
  - inhibit has no effect on a grant already issued.
- ack while in IDLE is ignored.
- slot_sync during GRANT does not affect the grant.

Optional Feature:
- Macro: SCHED_ROUND_ROBIN_EN.
- Defined: rotating priority. Search starts at the index after the last granted one, wrapping at NREQ-1; the last-granted pointer resets to NREQ-1, so the first search starts at index 0.
- Undefined: fixed priority, index 0 highest. The pointer register is absent.

Decomposition:
- Shared package ctr_sched_pkg holds:
  - state encoding (IDLE, GRANT);
  - default SLOT_CYCLES=12;
  - requester index constants (REQ_T1=0, REQ_T3=1, REQ_T4=2, REQ_T5=3, REQ_T6=4).
- One sub-module, ctr_prio_pick: combinational pick of one-hot winner from pending, plus an optional start-index input for round-robin.

Test Plan:
- Reset then single req_pulse[2] at phase 3 → pending=00100; grant=00100, grant_valid=1 at next phase 0; ack at phase 4 → grant=0 the next cycle, pending=0.
- req_pulse[1] and req_pulse[3] in the same cycle, ack each grant immediately → grants issued in consecutive slots, 00010 then 01000 (fixed priority); with SCHED_ROUND_ROBIN_EN after a prior grant of index 1 → 01000 first.
- Second req_pulse[0] while pending[0]=1 and ungranted → lost=00001 and stays set; lost_clr → lost=0; lost_clr and a new overrun in the same cycle → lost=00001.
- req_pulse[4] coincident with ack of grant[4] → pending[4] stays 1, lost[4]=0, re-granted one slot later.
- inhibit=1 across phase 11 with pending=00001 → no grant; inhibit=0 → grant at the following slot's phase 0.
- Grant outstanding, no ack for 3 slots → grant held constant; assert rst_=0 at phase 5 → all outputs 0 immediately, slot_phase=0.
